// File: rtl/rf_pkg.sv
// Shared defaults and types for the parametrised register file.
package rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_REG = 31;

  // Sweep FSM: CLEAR zeroes storage one entry per cycle, READY serves traffic.
  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side bus of the register file. The decode side (master)
// drives addresses and enables; the register file (slave) returns read data,
// busy flags, ready and its FSM state for observation.
// Handshake: there is no valid/ready pairing on individual transfers. A write
// or issue is taken on the clk edge where its enable is high and ready is 1;
// with ready low, enables are ignored and reads return zero.
interface regfile_scoreboard_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);
  logic [ADDR_W-1:0] read_addr1;
  logic [ADDR_W-1:0] read_addr2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              read_busy1;
  logic              read_busy2;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              write_enable;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_enable;
  logic              clear_req;
  logic              ready;
  rf_state_t         dbg_state;

  modport master (
    output read_addr1, read_addr2, write_addr, write_data, write_enable,
           issue_addr, issue_enable, clear_req,
    input  read_data1, read_data2, read_busy1, read_busy2, ready, dbg_state
  );

  modport slave (
    input  read_addr1, read_addr2, write_addr, write_data, write_enable,
           issue_addr, issue_enable, clear_req,
    output read_data1, read_data2, read_busy1, read_busy2, ready, dbg_state
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy vector: set on issue of a long-latency op, cleared by
// its writeback, flushed wholesale on a clear sweep. Two combinational lookups.
module rf_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] look_addr1,
  input  logic [ADDR_W-1:0] look_addr2,
  output logic              look_busy1,
  output logic              look_busy2
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy;

  // Clear is applied before set so a same-cycle writeback and issue leave the entry busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end

  assign look_busy1 = busy[look_addr1];
  assign look_busy2 = busy[look_addr2];
endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with hardwired-zero register, optional
// write-to-read bypass, busy scoreboard and a post-reset zeroing sweep.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = RF_ZERO_REG,
  parameter bit BYPASS   = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);
  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W:0]   LAST   = (ADDR_W + 1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  rf_state_t         state;
  logic [ADDR_W:0]   idx;
  logic              is_ready;
  logic              do_write;
  logic              do_issue;
  logic              busy1;
  logic              busy2;

  assign is_ready = (state == RF_READY);
  // A clear request in the same cycle drops any write or issue.
  assign do_write = is_ready && !bus.clear_req && bus.write_enable && (bus.write_addr != ZERO_A);
  assign do_issue = is_ready && !bus.clear_req && bus.issue_enable && (bus.issue_addr != ZERO_A);

  // Sweep FSM: walk idx from 0 to DEPTH-1, then serve traffic until a clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RF_CLEAR;
      idx   <= '0;
    end else if (state == RF_CLEAR) begin
      idx <= idx + 1'b1;
      if (idx == LAST) state <= RF_READY;
    end else if (bus.clear_req) begin
      state <= RF_CLEAR;
      idx   <= '0;
    end
  end

  // Storage: sweep writes zeros, otherwise commit accepted writebacks. No reset on the array.
  always_ff @(posedge clk) begin
    if (state == RF_CLEAR) begin
      mem[idx[ADDR_W-1:0]] <= '0;
    end else if (do_write) begin
      mem[bus.write_addr] <= bus.write_data;
    end
  end

  rf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (do_issue),
    .set_addr   (bus.issue_addr),
    .clr_en     (do_write),
    .clr_addr   (bus.write_addr),
    .flush      (is_ready && bus.clear_req),
    .look_addr1 (bus.read_addr1),
    .look_addr2 (bus.read_addr2),
    .look_busy1 (busy1),
    .look_busy2 (busy2)
  );

  // Read muxes: zero outside READY and for the zero register, bypass, then storage.
  always_comb begin
    bus.read_data1 = '0;
    bus.read_busy1 = 1'b0;
    bus.read_data2 = '0;
    bus.read_busy2 = 1'b0;
    if (is_ready && bus.read_addr1 != ZERO_A) begin
      if (BYPASS && bus.write_enable && bus.write_addr == bus.read_addr1) begin
        bus.read_data1 = bus.write_data;
      end else begin
        bus.read_data1 = mem[bus.read_addr1];
        bus.read_busy1 = busy1;
      end
    end
    if (is_ready && bus.read_addr2 != ZERO_A) begin
      if (BYPASS && bus.write_enable && bus.write_addr == bus.read_addr2) begin
        bus.read_data2 = bus.write_data;
      end else begin
        bus.read_data2 = mem[bus.read_addr2];
        bus.read_busy2 = busy2;
      end
    end
  end

  assign bus.ready     = is_ready;
  assign bus.dbg_state = state;
endmodule
